// File: rtl/mole_scheduler.sv
// Popup scheduler: records {addr, loc} pairs, replays them against music_address.
// Optional MOLE_SCHEDULER_LOOP_EN: wraps to entry 0 when the song restarts.
module mole_scheduler #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 23,
    parameter int LOC_W  = 3,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              restart,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [LOC_W-1:0]  wr_loc,
    input  logic              clear,
    input  logic [ADDR_W-1:0] music_address,
    output logic              mole_valid,
    output logic [LOC_W-1:0]  mole_location,
    input  logic              mole_ack,
    output logic [IDX_W:0]    count,
    output logic              full,
    output logic              overflow,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_MATCH,
        ISSUE,
`ifdef MOLE_SCHEDULER_LOOP_EN
        WRAP,
`endif
        DONE
    } state_e;

`ifdef MOLE_SCHEDULER_LOOP_EN
    localparam state_e END_ST   = WRAP;
    localparam state_e EMPTY_ST = IDLE;
`else
    localparam state_e END_ST   = DONE;
    localparam state_e EMPTY_ST = DONE;
`endif

    localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(DEPTH);

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [LOC_W-1:0]  loc_mem  [DEPTH];

    state_e            state_q;
    logic [IDX_W:0]    idx_q;
    logic [IDX_W:0]    idx_d;
    logic [IDX_W:0]    count_q;
    logic              overflow_q;
    logic [ADDR_W-1:0] cur_addr_q;
    logic [LOC_W-1:0]  cur_loc_q;
    logic              valid_q;
    logic [LOC_W-1:0]  loc_q;
    logic              full_d;
    logic              wr_ok;

    assign full_d = (count_q == DEPTH_C);
    assign idx_d  = idx_q + 1'b1;
    assign wr_ok  = wr_en & ~enable & ~full_d & ~clear;

    assign mole_valid    = valid_q;
    assign mole_location = loc_q;
    assign count         = count_q;
    assign full          = full_d;
    assign overflow      = overflow_q;
    assign done          = (state_q == DONE);

    // Table storage; contents are only read below count so need no reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            addr_mem[count_q[IDX_W-1:0]] <= wr_addr;
            loc_mem[count_q[IDX_W-1:0]]  <= wr_loc;
        end
    end

    // Record bookkeeping plus the playback FSM with registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            cur_addr_q <= '0;
            cur_loc_q  <= '0;
            valid_q    <= 1'b0;
            loc_q      <= '0;
        end else if (clear) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
            loc_q      <= '0;
        end else begin
            if (wr_en && !enable) begin
                if (full_d) overflow_q <= 1'b1;
                else        count_q    <= count_q + 1'b1;
            end
            if (!enable) begin
                state_q <= IDLE;
                idx_q   <= '0;
                valid_q <= 1'b0;
                loc_q   <= '0;
            end else if (restart) begin
                idx_q   <= '0;
                valid_q <= 1'b0;
                loc_q   <= '0;
                state_q <= (count_q != '0) ? LOAD : EMPTY_ST;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        state_q <= (count_q != '0) ? LOAD : EMPTY_ST;
                    end
                    LOAD: begin
                        cur_addr_q <= addr_mem[idx_q[IDX_W-1:0]];
                        cur_loc_q  <= loc_mem[idx_q[IDX_W-1:0]];
                        state_q    <= WAIT_MATCH;
                    end
                    WAIT_MATCH: begin
                        if (music_address >= cur_addr_q) begin
                            valid_q <= 1'b1;
                            loc_q   <= cur_loc_q;
                            state_q <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        if (mole_ack) begin
                            valid_q <= 1'b0;
                            loc_q   <= '0;
                            idx_q   <= idx_d;
                            state_q <= (idx_d < count_q) ? LOAD : END_ST;
                        end
                    end
`ifdef MOLE_SCHEDULER_LOOP_EN
                    WRAP: begin
                        if (music_address < addr_mem[0]) begin
                            idx_q   <= '0;
                            state_q <= LOAD;
                        end
                    end
`endif
                    DONE: begin
                        state_q <= DONE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mole_scheduler.sv
// Scoreboard bench for mole_scheduler (DEPTH=4 build).
// Expectations follow MOLE_SCHEDULER_LOOP_EN when it is defined.
module tb_mole_scheduler;

    localparam int AW = 23;
    localparam int LW = 3;
    localparam int IW = 2;

`ifdef MOLE_SCHEDULER_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic          clk;
    logic          reset_n;
    logic          enable;
    logic          restart;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [LW-1:0] wr_loc;
    logic          clear;
    logic [AW-1:0] music_address;
    logic          mole_valid;
    logic [LW-1:0] mole_location;
    logic          mole_ack;
    logic [IW:0]   count;
    logic          full;
    logic          overflow;
    logic          done;

    int n_chk;
    int n_fail;
    logic [LW-1:0] exp_q[$];

    mole_scheduler #(
        .DEPTH (4),
        .ADDR_W(AW),
        .LOC_W (LW),
        .IDX_W (IW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .restart      (restart),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_loc       (wr_loc),
        .clear        (clear),
        .music_address(music_address),
        .mole_valid   (mole_valid),
        .mole_location(mole_location),
        .mole_ack     (mole_ack),
        .count        (count),
        .full         (full),
        .overflow     (overflow),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic rec(input logic [AW-1:0] a, input logic [LW-1:0] l);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_loc  = l;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic ack();
        mole_ack = 1'b1;
        tick();
        mole_ack = 1'b0;
    endtask

    // Wait for an issue, compare against scoreboard head, then ack it.
    task automatic expect_issue(input string tag, input int budget);
        int n;
        logic [LW-1:0] e;
        n = 0;
        while (!mole_valid && n < budget) begin
            tick();
            n++;
        end
        if (!mole_valid) begin
            chk({tag, "_timeout"}, 32'(mole_valid), 32'd1);
        end else if (exp_q.size() == 0) begin
            chk({tag, "_unexpected"}, 32'(mole_valid), 32'd0);
            ack();
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_loc"}, 32'(mole_location), 32'(e));
            ack();
        end
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        reset_n = 1'b0;
        enable = 1'b0;
        restart = 1'b0;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_loc = '0;
        clear = 1'b0;
        music_address = '0;
        mole_ack = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(mole_valid), 0);
        chk("rst_loc", 32'(mole_location), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_done", 32'(done), 0);
        reset_n = 1'b1;
        tick();

        // Basic two-entry playback with exact match timing.
        rec(23'h100, 3'd2);
        rec(23'h200, 3'd5);
        chk("rec_count", 32'(count), 2);
        mole_ack = 1'b1;
        tick();
        mole_ack = 1'b0;
        enable = 1'b1;
        music_address = 23'h0FF;
        repeat (5) tick();
        chk("early_valid", 32'(mole_valid), 0);
        exp_q.push_back(3'd2);
        exp_q.push_back(3'd5);
        music_address = 23'h100;
        tick();
        chk("match_latency", 32'(mole_valid), 1);
        expect_issue("e0", 1);
        chk("post_ack_valid", 32'(mole_valid), 0);
        music_address = 23'h1FF;
        repeat (4) tick();
        chk("e1_early", 32'(mole_valid), 0);
        music_address = 23'h200;
        tick();
        chk("e1_latency", 32'(mole_valid), 1);
        expect_issue("e1", 1);
        chk("end_done", 32'(done), 32'(!LOOP));

        // Song restart: loop build re-issues entry 0, default stays done.
        music_address = 23'h0;
        repeat (3) tick();
        music_address = 23'h100;
        if (LOOP) begin
            exp_q.push_back(3'd2);
            expect_issue("wrap", 6);
        end else begin
            repeat (6) tick();
            chk("noloop_valid", 32'(mole_valid), 0);
        end
        chk("wrap_done", 32'(done), 32'(!LOOP));
        enable = 1'b0;
        tick();
        chk("dis_done", 32'(done), 0);

        // Jump past all entries: three ordered issues, none dropped.
        pulse_clear();
        rec(23'h10, 3'd1);
        rec(23'h20, 3'd3);
        rec(23'h30, 3'd6);
        music_address = 23'h0;
        enable = 1'b1;
        rec(23'h40, 3'd7);
        chk("wr_while_en", 32'(count), 3);
        repeat (3) tick();
        chk("jump_pre", 32'(mole_valid), 0);
        exp_q.push_back(3'd1);
        exp_q.push_back(3'd3);
        exp_q.push_back(3'd6);
        music_address = 23'h500;
        for (int i = 0; i < 3; i++) expect_issue("burst", 6);
        tick();
        chk("burst_done", 32'(done), 32'(!LOOP));

        // Restart mid-song replays from entry 0.
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("restart_done", 32'(done), 0);
        exp_q.push_back(3'd1);
        expect_issue("restart", 6);
        enable = 1'b0;
        tick();

        // Held issue stays stable, enable drop, then async reset.
        pulse_clear();
        rec(23'h40, 3'd4);
        music_address = 23'h40;
        enable = 1'b1;
        repeat (4) tick();
        for (int i = 0; i < 10; i++) begin
            chk("hold_valid", 32'(mole_valid), 1);
            chk("hold_loc", 32'(mole_location), 4);
            tick();
        end
        enable = 1'b0;
        tick();
        chk("en_drop_valid", 32'(mole_valid), 0);
        enable = 1'b1;
        repeat (4) tick();
        chk("reissue_valid", 32'(mole_valid), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_valid", 32'(mole_valid), 0);
        chk("arst_loc", 32'(mole_location), 0);
        chk("arst_count", 32'(count), 0);
        enable = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();

        // Fill to DEPTH, overflow keeps entry 3 intact, then clear.
        for (int i = 0; i < 4; i++) rec(23'(16 * (i + 1)), 3'(i + 1));
        chk("fill_count", 32'(count), 4);
        chk("fill_full", 32'(full), 1);
        chk("fill_ovf", 32'(overflow), 0);
        rec(23'h999, 3'd7);
        chk("ovf_count", 32'(count), 4);
        chk("ovf_flag", 32'(overflow), 1);
        music_address = 23'hFFF;
        enable = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(3'(i + 1));
        for (int i = 0; i < 4; i++) expect_issue("full_play", 6);
        tick();
        chk("full_done", 32'(done), 32'(!LOOP));
        enable = 1'b0;
        tick();
        pulse_clear();
        chk("clr_count", 32'(count), 0);
        chk("clr_ovf", 32'(overflow), 0);
        chk("clr_full", 32'(full), 0);
        enable = 1'b1;
        repeat (3) tick();
        chk("empty_done", 32'(done), 32'(!LOOP));
        chk("empty_valid", 32'(mole_valid), 0);
        chk("sb_drained", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
